// File: rtl/triangle_pkg.sv
// Shared types and helpers for the triangle rasterizer: coordinate type,
// scanner states and signed min/max of three coordinates.
package triangle_pkg;

  localparam int unsigned W = 10;

  typedef logic signed [W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BBOX = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } scan_state_t;

  function automatic coord_t min3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic coord_t max3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/triangle.sv
// Combinational point-in-triangle test. Edge and vertex points are inside;
// works for either winding and for degenerate (collinear) triangles.
module triangle
  import triangle_pkg::*;
(
  input  logic signed [W-1:0] i_px,
  input  logic signed [W-1:0] i_py,
  input  logic signed [W-1:0] i_ax,
  input  logic signed [W-1:0] i_ay,
  input  logic signed [W-1:0] i_bx,
  input  logic signed [W-1:0] i_by,
  input  logic signed [W-1:0] i_cx,
  input  logic signed [W-1:0] i_cy,
  output logic                o_inside
);

  localparam int unsigned CW = 2 * W + 4;

  // Cross product of edge (u->v) with (u->p); wide enough to never overflow.
  function automatic logic signed [CW-1:0] edge_fn(coord_t ux, coord_t uy,
                                                   coord_t vx, coord_t vy,
                                                   coord_t px, coord_t py);
    logic signed [CW-1:0] dx, dy, qx, qy;
    dx = CW'(vx) - CW'(ux);
    dy = CW'(vy) - CW'(uy);
    qx = CW'(px) - CW'(ux);
    qy = CW'(py) - CW'(uy);
    return (dx * qy) - (dy * qx);
  endfunction

  logic signed [CW-1:0] w_e0, w_e1, w_e2;
  logic                 w_all_nonneg, w_all_nonpos;

  assign w_e0 = edge_fn(i_ax, i_ay, i_bx, i_by, i_px, i_py);
  assign w_e1 = edge_fn(i_bx, i_by, i_cx, i_cy, i_px, i_py);
  assign w_e2 = edge_fn(i_cx, i_cy, i_ax, i_ay, i_px, i_py);

  assign w_all_nonneg = !w_e0[CW-1] && !w_e1[CW-1] && !w_e2[CW-1];
  assign w_all_nonpos = (w_e0 <= 0) && (w_e1 <= 0) && (w_e2 <= 0);
  assign o_inside     = w_all_nonneg || w_all_nonpos;

endmodule

// File: rtl/triangle_scanner.sv
// Rasterizer front end: latches a triangle, walks its bounding box in raster
// order and streams the inside points over a valid/ready handshake.
module triangle_scanner
  import triangle_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [W-1:0]   p1x,
  input  logic signed [W-1:0]   p1y,
  input  logic signed [W-1:0]   p2x,
  input  logic signed [W-1:0]   p2y,
  input  logic signed [W-1:0]   p3x,
  input  logic signed [W-1:0]   p3y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [W-1:0]   out_x,
  output logic signed [W-1:0]   out_y,
  output logic                  done,
  output logic [2*W-1:0]        pix_count
);

  localparam int unsigned CNT_W = 2 * W;

  scan_state_t      r_state, w_next;
  coord_t           r_v1x, r_v1y, r_v2x, r_v2y, r_v3x, r_v3y;
  coord_t           r_xmin, r_xmax, r_ymax;
  coord_t           r_cx, r_cy;
  logic [CNT_W-1:0] r_pix_count;
  logic             w_inside, w_accept, w_retire, w_last;

  triangle u_triangle (
    .i_px     (r_cx),
    .i_py     (r_cy),
    .i_ax     (r_v1x),
    .i_ay     (r_v1y),
    .i_bx     (r_v2x),
    .i_by     (r_v2y),
    .i_cx     (r_v3x),
    .i_cy     (r_v3y),
    .o_inside (w_inside)
  );

  assign w_accept = (r_state == IDLE) && in_valid;
  // Outside points retire unconditionally; inside points wait for the consumer.
  assign w_retire = (r_state == SCAN) && (!w_inside || out_ready);
  assign w_last   = (r_cx == r_xmax) && (r_cy == r_ymax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = BBOX;
      BBOX:    w_next = SCAN;
      SCAN:    if (w_retire && w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1x       <= '0;
      r_v1y       <= '0;
      r_v2x       <= '0;
      r_v2y       <= '0;
      r_v3x       <= '0;
      r_v3y       <= '0;
      r_xmin      <= '0;
      r_xmax      <= '0;
      r_ymax      <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_pix_count <= '0;
    end else begin
      if (w_accept) begin
        r_v1x       <= p1x;
        r_v1y       <= p1y;
        r_v2x       <= p2x;
        r_v2y       <= p2y;
        r_v3x       <= p3x;
        r_v3y       <= p3y;
        r_pix_count <= '0;
      end
      if (r_state == BBOX) begin
        r_xmin <= min3(r_v1x, r_v2x, r_v3x);
        r_xmax <= max3(r_v1x, r_v2x, r_v3x);
        r_ymax <= max3(r_v1y, r_v2y, r_v3y);
        r_cx   <= min3(r_v1x, r_v2x, r_v3x);
        r_cy   <= min3(r_v1y, r_v2y, r_v3y);
      end
      // Equality tests before increment keep the walk safe at the max coordinate.
      if (w_retire) begin
        if (w_inside) r_pix_count <= r_pix_count + CNT_W'(1);
        if (r_cx != r_xmax) begin
          r_cx <= r_cx + coord_t'(1);
        end else if (r_cy != r_ymax) begin
          r_cx <= r_xmin;
          r_cy <= r_cy + coord_t'(1);
        end
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == SCAN) && w_inside;
  assign out_x     = r_cx;
  assign out_y     = r_cy;
  assign done      = (r_state == DONE);
  assign pix_count = r_pix_count;

endmodule

// File: tb/tb_triangle_scanner.sv
// Self-checking bench for triangle_scanner: table of triangles with expected
// point streams, scoreboard queue, stall/busy and mid-scan reset sequences.
module tb_triangle_scanner;
  import triangle_pkg::*;

  localparam int BUDGET = 300;
  localparam int NVEC   = 5;

  typedef struct {
    int ax, ay, bx, by, cx, cy;
    int n;
    int ex[9];
    int ey[9];
    int done_c;
  } vec_t;

  typedef struct {
    int x;
    int y;
  } pt_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] p1x, p1y, p2x, p2y, p3x, p3y;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_x, out_y;
  logic                done;
  logic [2*W-1:0]      pix_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[NVEC];
  pt_t  sb[$];

  triangle_scanner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p1x       (p1x),
    .p1y       (p1y),
    .p2x       (p2x),
    .p2y       (p2y),
    .p3x       (p3x),
    .p3y       (p3y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .done      (done),
    .pix_count (pix_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_tri(input vec_t v);
    p1x = W'(v.ax); p1y = W'(v.ay);
    p2x = W'(v.bx); p2y = W'(v.by);
    p3x = W'(v.cx); p3y = W'(v.cy);
  endtask

  task automatic run_job(input int idx, input int stall, input bit busy,
                         input int abort_after);
    vec_t v;
    bit   held;
    bit   got_done;
    int   stall_left;
    int   pops;
    int   hx, hy;
    pt_t  p;
    v = vecs[idx];
    held = 1'b0; got_done = 1'b0; stall_left = 0; pops = 0; hx = 0; hy = 0;
    for (int i = 0; i < v.n; i++) sb.push_back('{v.ex[i], v.ey[i]});
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 1);
    drive_tri(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (c == 1) chk("bbox_in_ready", int'(in_ready), 0);
      if (busy && c == 3) begin
        chk("busy_in_ready", int'(in_ready), 0);
        drive_tri(vecs[3]);
        in_valid = 1'b1;
      end
      if (done) begin
        got_done = 1'b1;
        chk("done_cycle", c, v.done_c + stall * v.n);
        break;
      end
      if (out_valid) begin
        if (!held) begin
          held = 1'b1; stall_left = stall; hx = int'(out_x); hy = int'(out_y);
        end else begin
          chk("stall_hold_x", int'(out_x), hx);
          chk("stall_hold_y", int'(out_y), hy);
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          held = 1'b0;
          if (sb.size() == 0) begin
            chk("unexpected_point", 1, 0);
          end else begin
            p = sb.pop_front();
            chk("point_x", int'(out_x), p.x);
            chk("point_y", int'(out_y), p.y);
          end
          pops++;
          if (pops == abort_after) begin
            @(posedge clk);
            #1;
            chk("pre_reset_valid", int'(out_valid), 1);
            #1;
            rst_n = 1'b0;
            #1;
            chk("rst_valid_drop", int'(out_valid), 0);
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_pix_count", int'(pix_count), 0);
            for (int k = 0; k < 3; k++) begin
              @(negedge clk);
              chk("rst_no_done", int'(done), 0);
            end
            rst_n = 1'b1;
            sb.delete();
            return;
          end
        end
      end else begin
        out_ready = 1'b1;
        held = 1'b0;
      end
    end
    if (!got_done) chk("done_timeout", 0, 1);
    chk("pix_count", int'(pix_count), v.n);
    chk("points_left", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    chk("done_pulse_end", int'(done), 0);
    chk("in_ready_return", int'(in_ready), 1);
    chk("out_valid_idle", int'(out_valid), 0);
    chk("pix_count_hold", int'(pix_count), v.n);
  endtask

  initial begin
    vecs[0] = '{0, 0, 2, 0, 0, 2, 6,
                '{0, 1, 2, 0, 1, 0, 0, 0, 0}, '{0, 0, 0, 1, 1, 2, 0, 0, 0}, 11};
    vecs[1] = '{-3, -3, -1, -3, -3, -1, 6,
                '{-3, -2, -1, -3, -2, -3, 0, 0, 0}, '{-3, -3, -3, -2, -2, -1, 0, 0, 0}, 11};
    vecs[2] = '{5, 5, 5, 5, 5, 5, 1,
                '{5, 0, 0, 0, 0, 0, 0, 0, 0}, '{5, 0, 0, 0, 0, 0, 0, 0, 0}, 3};
    vecs[3] = '{0, 0, 2, 2, 1, 1, 3,
                '{0, 1, 2, 0, 0, 0, 0, 0, 0}, '{0, 1, 2, 0, 0, 0, 0, 0, 0}, 11};
    vecs[4] = '{510, 510, 511, 510, 510, 511, 3,
                '{510, 511, 510, 0, 0, 0, 0, 0, 0}, '{510, 510, 511, 0, 0, 0, 0, 0, 0}, 6};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    p1x = '0; p1y = '0; p2x = '0; p2y = '0; p3x = '0; p3y = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      p1x = W'($urandom); p1y = W'($urandom);
      p2x = W'($urandom); p2y = W'($urandom);
      p3x = W'($urandom); p3y = W'($urandom);
      #1;
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_pix_count", int'(pix_count), 0);
      chk("reset_out_x", int'(out_x), 0);
      chk("reset_out_y", int'(out_y), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < NVEC; i++) run_job(i, 0, 1'b0, -1);
    run_job(0, 3, 1'b1, -1);
    run_job(0, 0, 1'b0, 2);
    run_job(0, 0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
